load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request and data-memory signals of the load/store unit, grouped as one bundle.
// slave = the unit itself; master = the core/memory environment driving it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  memRW;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic        err;

  modport slave (
    input  req_valid, memRW, func3, addr, store_data, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, done, load_data, err
  );

  modport master (
    output req_valid, memRW, func3, addr, store_data, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, done, load_data, err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one op at a time, done 2 cycles after acceptance at best (1 on error).
// req_ready only in IDLE; mem_req held until mem_ack or the watchdog expires.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_wdog;
  logic        r_mem_req, r_mem_we, r_err, r_is_load;
  logic [31:0] r_mem_addr, r_mem_wdata, r_load_data;
  logic [3:0]  r_mem_wstrb;
  logic [2:0]  r_func3;
  logic [1:0]  r_byte_sel;

  logic        w_accept, w_is_load, w_func_ok, w_misalign, w_req_err, w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_accept  = (r_state == IDLE) && bus.req_valid &&
                ((bus.memRW == 2'b01) || (bus.memRW == 2'b10));
    w_is_load = (bus.memRW == 2'b01);
    w_func_ok = 1'b0;
    case (bus.func3)
      3'b000, 3'b001, 3'b010: w_func_ok = 1'b1;
      3'b100, 3'b101:         w_func_ok = w_is_load;
      default:                w_func_ok = 1'b0;
    endcase
    w_misalign = ((bus.func3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.func3 == 3'b010) && (bus.addr[1:0] != 2'b00));
    w_req_err  = !w_func_ok || w_misalign;
    w_wstrb = 4'b1111;
    w_wdata = bus.store_data;
    case (bus.func3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << bus.addr[1:0];
        w_wdata = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << {bus.addr[1], 1'b0};
        w_wdata = {2{bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension use the request fields latched at acceptance.
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_byte_sel)
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      2'd3:    w_byte = bus.mem_rdata[31:24];
      default: w_byte = bus.mem_rdata[7:0];
    endcase
    w_half = r_byte_sel[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    w_ext  = bus.mem_rdata;
    case (r_func3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = bus.mem_rdata;
    endcase
  end

  assign w_timeout = (r_wdog == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_req_err ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ack || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog      <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_load_data <= 32'd0;
      r_err       <= 1'b0;
      r_is_load   <= 1'b0;
      r_func3     <= 3'd0;
      r_byte_sel  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_func3     <= bus.func3;
          r_byte_sel  <= bus.addr[1:0];
          r_is_load   <= w_is_load;
          r_load_data <= 32'd0;
          r_err       <= w_req_err;
          r_wdog      <= 8'd0;
          if (!w_req_err) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= !w_is_load;
            r_mem_addr  <= {bus.addr[31:2], 2'b00};
            r_mem_wstrb <= w_is_load ? 4'd0 : w_wstrb;
            r_mem_wdata <= w_is_load ? 32'd0 : w_wdata;
          end
        end
        // An ack in the final watchdog cycle still wins over the timeout.
        ACCESS: if (bus.mem_ack) begin
          r_mem_req <= 1'b0;
          if (r_is_load) r_load_data <= w_ext;
        end else begin
          r_wdog <= r_wdog + 8'd1;
          if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
          end
        end
        RESP: begin
          r_err       <= 1'b0;
          r_load_data <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.done      = (r_state == RESP);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.load_data = r_load_data;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at default TIMEOUT, one at TIMEOUT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_load_store_unit;
  logic clk;
  logic rst_a, rst_b;
  int   n_checks;
  int   n_fail;

  load_store_unit_if a ();
  load_store_unit_if b ();

  load_store_unit u_dut_a (.clk(clk), .rst_n(rst_a), .bus(a));
  load_store_unit #(.TIMEOUT(4)) u_dut_b (.clk(clk), .rst_n(rst_b), .bus(b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue_a(input logic [1:0] rw, input logic [2:0] f3,
                         input logic [31:0] ad, input logic [31:0] sd);
    @(negedge clk);
    a.req_valid = 1'b1; a.memRW = rw; a.func3 = f3; a.addr = ad; a.store_data = sd;
    @(negedge clk);
    a.req_valid = 1'b0;
  endtask

  task automatic load_a(input string tag, input logic [2:0] f3, input logic [31:0] ad,
                        input logic [31:0] rdata, input logic [31:0] exp_ld);
    issue_a(2'b01, f3, ad, 32'd0);
    chk({tag, "_req"},   32'(a.mem_req), 32'd1);
    chk({tag, "_we"},    32'(a.mem_we), 32'd0);
    chk({tag, "_maddr"}, a.mem_addr, {ad[31:2], 2'b00});
    chk({tag, "_wstrb"}, 32'(a.mem_wstrb), 32'd0);
    chk({tag, "_early"}, 32'(a.done), 32'd0);
    a.mem_ack = 1'b1; a.mem_rdata = rdata;
    @(negedge clk);
    a.mem_ack = 1'b0; a.mem_rdata = 32'd0;
    chk({tag, "_done"},  32'(a.done), 32'd1);
    chk({tag, "_err"},   32'(a.err), 32'd0);
    chk({tag, "_data"},  a.load_data, exp_ld);
    chk({tag, "_reqlo"}, 32'(a.mem_req), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(a.done), 32'd0);
  endtask

  task automatic err_a(input string tag, input logic [1:0] rw, input logic [2:0] f3,
                       input logic [31:0] ad);
    issue_a(rw, f3, ad, 32'hFFFF_FFFF);
    chk({tag, "_done"}, 32'(a.done), 32'd1);
    chk({tag, "_err"},  32'(a.err), 32'd1);
    chk({tag, "_req"},  32'(a.mem_req), 32'd0);
    chk({tag, "_data"}, a.load_data, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(a.done), 32'd0);
    chk({tag, "_ready"}, 32'(a.req_ready), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    a.req_valid = 0; a.memRW = 0; a.func3 = 0; a.addr = 0; a.store_data = 0;
    a.mem_ack = 0; a.mem_rdata = 0;
    b.req_valid = 0; b.memRW = 0; b.func3 = 0; b.addr = 0; b.store_data = 0;
    b.mem_ack = 0; b.mem_rdata = 0;

    @(negedge clk);
    chk("rst_ready", 32'(a.req_ready), 32'd1);
    chk("rst_req",   32'(a.mem_req), 32'd0);
    chk("rst_we",    32'(a.mem_we), 32'd0);
    chk("rst_addr",  a.mem_addr, 32'd0);
    chk("rst_wstrb", 32'(a.mem_wstrb), 32'd0);
    chk("rst_wdata", a.mem_wdata, 32'd0);
    chk("rst_done",  32'(a.done), 32'd0);
    chk("rst_err",   32'(a.err), 32'd0);
    chk("rst_ld",    a.load_data, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    // Loads: sign/zero extension and lane selection.
    load_a("lb",  3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
    load_a("lhu", 3'b101, 32'h0000_0102, 32'h9ABC_5678, 32'h0000_9ABC);
    load_a("lh",  3'b001, 32'h0000_0102, 32'h9ABC_5678, 32'hFFFF_9ABC);
    load_a("lbu", 3'b100, 32'h0000_0101, 32'h80FF_9234, 32'h0000_0092);
    load_a("lw",  3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // SH with a slow ack and a stray request while busy.
    issue_a(2'b10, 3'b001, 32'h0000_0206, 32'h1234_ABCD);
    chk("sh_we",    32'(a.mem_we), 32'd1);
    chk("sh_addr",  a.mem_addr, 32'h0000_0204);
    chk("sh_wstrb", 32'(a.mem_wstrb), 32'hC);
    chk("sh_wdata", a.mem_wdata, 32'hABCD_ABCD);
    chk("sh_ready", 32'(a.req_ready), 32'd0);
    for (int i = 1; i < 5; i++) begin
      if (i == 2) begin
        a.req_valid = 1'b1; a.memRW = 2'b01; a.func3 = 3'b010; a.addr = 32'h0000_0400;
      end else begin
        a.req_valid = 1'b0;
      end
      @(negedge clk);
      chk("sh_hold_req",  32'(a.mem_req), 32'd1);
      chk("sh_hold_addr", a.mem_addr, 32'h0000_0204);
      chk("sh_hold_done", 32'(a.done), 32'd0);
    end
    a.req_valid = 1'b0;
    a.mem_ack = 1'b1;
    @(negedge clk);
    a.mem_ack = 1'b0;
    chk("sh_done", 32'(a.done), 32'd1);
    chk("sh_err",  32'(a.err), 32'd0);
    chk("sh_ld",   a.load_data, 32'd0);
    @(negedge clk);
    chk("sh_idle_req",  32'(a.mem_req), 32'd0);
    chk("sh_idle_done", 32'(a.done), 32'd0);
    @(negedge clk);
    chk("sh_noqueue", 32'(a.mem_req), 32'd0);

    // SB to the top byte lane.
    issue_a(2'b10, 3'b000, 32'h0000_0203, 32'h7766_55A5);
    chk("sb_addr",  a.mem_addr, 32'h0000_0200);
    chk("sb_wstrb", 32'(a.mem_wstrb), 32'h8);
    chk("sb_wdata", a.mem_wdata, 32'hA5A5_A5A5);
    a.mem_ack = 1'b1;
    @(negedge clk);
    a.mem_ack = 1'b0;
    chk("sb_done", 32'(a.done), 32'd1);
    chk("sb_err",  32'(a.err), 32'd0);

    // Misaligned and illegal encodings.
    err_a("lw_mis",   2'b01, 3'b010, 32'h0000_0301);
    err_a("lh_mis",   2'b01, 3'b001, 32'h0000_0105);
    err_a("ld_f011",  2'b01, 3'b011, 32'h0000_0100);
    err_a("st_f100",  2'b10, 3'b100, 32'h0000_0100);
    err_a("sw_mis",   2'b10, 3'b010, 32'h0000_0102);

    // No-op/reserved memRW and a stray ack in IDLE do nothing.
    @(negedge clk);
    a.req_valid = 1'b1; a.memRW = 2'b00; a.func3 = 3'b010; a.addr = 32'h10;
    @(negedge clk);
    chk("nop_ready", 32'(a.req_ready), 32'd1);
    chk("nop_done",  32'(a.done), 32'd0);
    chk("nop_req",   32'(a.mem_req), 32'd0);
    a.memRW = 2'b11;
    @(negedge clk);
    chk("rsv_done", 32'(a.done), 32'd0);
    chk("rsv_req",  32'(a.mem_req), 32'd0);
    a.req_valid = 1'b0; a.mem_ack = 1'b1;
    @(negedge clk);
    a.mem_ack = 1'b0;
    chk("ack_idle_done", 32'(a.done), 32'd0);
    chk("ack_idle_rdy",  32'(a.req_ready), 32'd1);

    // TIMEOUT=4: SW never acked.
    @(negedge clk);
    b.req_valid = 1'b1; b.memRW = 2'b10; b.func3 = 3'b010; b.addr = 32'h500;
    b.store_data = 32'h1122_3344;
    @(negedge clk);
    b.req_valid = 1'b0;
    chk("to_wstrb", 32'(b.mem_wstrb), 32'hF);
    chk("to_wdata", b.mem_wdata, 32'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_hi", 32'(b.mem_req), 32'd1);
      chk("to_nodone", 32'(b.done), 32'd0);
      @(negedge clk);
    end
    chk("to_done", 32'(b.done), 32'd1);
    chk("to_err",  32'(b.err), 32'd1);
    chk("to_req",  32'(b.mem_req), 32'd0);

    // Ack in the last watchdog cycle completes cleanly.
    @(negedge clk);
    b.req_valid = 1'b1; b.memRW = 2'b01; b.func3 = 3'b010; b.addr = 32'h600;
    @(negedge clk);
    b.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("edge_req", 32'(b.mem_req), 32'd1);
    b.mem_ack = 1'b1; b.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    b.mem_ack = 1'b0;
    chk("edge_done", 32'(b.done), 32'd1);
    chk("edge_err",  32'(b.err), 32'd0);
    chk("edge_ld",   b.load_data, 32'hCAFE_F00D);

    // Reset mid-ACCESS, then a late ack.
    @(negedge clk);
    b.req_valid = 1'b1; b.memRW = 2'b10; b.func3 = 3'b010; b.addr = 32'h700;
    @(negedge clk);
    b.req_valid = 1'b0;
    @(negedge clk);
    chk("rm_req_before", 32'(b.mem_req), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    chk("rm_req_async", 32'(b.mem_req), 32'd0);
    chk("rm_done",      32'(b.done), 32'd0);
    chk("rm_ready",     32'(b.req_ready), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    b.mem_ack = 1'b1;
    @(negedge clk);
    b.mem_ack = 1'b0;
    chk("rm_late_done", 32'(b.done), 32'd0);
    chk("rm_late_req",  32'(b.mem_req), 32'd0);
    @(negedge clk);
    chk("rm_after_done", 32'(b.done), 32'd0);
    chk("rm_after_rdy",  32'(b.req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
